fp16_pair_unpacker: RTL and testbench
=====================================

Name: fp16_pair_unpacker

Overview:
Upstream feeder for fp16_to_fp32. Accepts 32-bit bus words, each carrying two packed fp16 lanes, over a valid/ready handshake. Emits one fp16 value per cycle over a second valid/ready handshake, directly into the fp16-to-fp32 converter. Supports partial words via a per-lane keep mask, propagates a packet-last marker, and counts emitted values.

Parameters:
- LOW_FIRST, 1: 1 = emit lane 0 (bits [15:0]) before lane 1 (bits [31:16]); 0 = reverse order.
- CNT_W, 16: width of the emitted-value counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  32  two packed fp16 values: lane0 = [15:0], lane1 = [31:16].
- in_keep  input  2  per-lane valid mask; bit0 = lane0, bit1 = lane1.
- in_last  input  1  word is the final word of a packet.
- out_valid  output  1  out_data holds a valid fp16.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  16  fp16 value, forwarded to fp16_to_fp32.fp16_in.
- out_last  output  1  out_data is the final fp16 of a packet.
- drop_pulse  output  1  one-cycle pulse when a word with in_keep==2'b00 is accepted.
- out_count  output  CNT_W  number of fp16 values emitted since reset; wraps modulo 2^CNT_W.

Behaviour:
- Handshakes:
  - A transfer occurs on a clock edge where valid && ready.
  - in_valid and in_data must stay stable until accepted; out_valid and out_data stay stable until accepted.
- Storage: one word register holding data, keep and last, plus a lane pointer.
- State machine, three states:
  - IDLE: no word held.
  - FIRST: emitting the first-ordered kept lane.
  - SECOND: emitting the second-ordered lane.
- Lane order: the first-ordered lane is lane0 when LOW_FIRST=1, else lane1. Lanes with keep=0 are skipped and never emitted.
- Accepting a word (from IDLE):
  - both lanes kept -> FIRST, then SECOND.
  - exactly one lane kept -> FIRST only; that lane is final.
  - keep==00 -> word is discarded and stays in IDLE; drop_pulse=1 the next cycle; in_last of that word is discarded.
- out_valid = 1 in FIRST and SECOND; out_data = the selected lane.
- out_last = stored last && current lane is the final kept lane of the word.
- in_ready rule:
  - in_ready = !rst && (state==IDLE || (out_valid && out_ready && current lane is the final lane)).
  - This permits back-to-back words with no bubble, so throughput is one fp16 per cycle.
  - There is a combinational path out_ready -> in_ready.
- Simultaneous final-lane output transfer and input acceptance: the new word loads and the state goes directly to FIRST (or IDLE if keep==00).
- Latency: an accepted word's first lane is presented on out_data in the cycle after acceptance.
- out_count increments by 1 on each output transfer; 2^CNT_W-1 wraps to 0.
- NaN, Inf and denorm values pass through bit-exact; the block does no fp16 interpretation.
- Reset (rst high at a clock edge):
  - state=IDLE, out_valid=0, out_last=0, drop_pulse=0, out_count=0, out_data=16'h0000.
  - A held word is discarded mid-operation.
  - in_ready=0 while rst is high, so no word is accepted during the reset cycle.
- Backpressure: while out_valid && !out_ready, state, out_data and out_last hold unchanged, and in_ready=0.

Test Plan:
- Reset, then word 0xC0003C00, keep=11, last=0, out_ready=1, LOW_FIRST=1 -> out_data 0x3C00 then 0xC000 on consecutive cycles; out_last=0 both; out_count=2.
- Three back-to-back words, keep=11, out_ready=1 -> six outputs in six consecutive cycles with no bubble; in_ready high every second cycle; out_last=1 only on the 6th output when the 3rd word has last=1.
- Word 0x7E00FC00, keep=10, last=1 -> single output 0x7E00 with out_last=1; with LOW_FIRST=0 and keep=11 -> 0x7E00 then 0xFC00, with out_last on 0xFC00.
- Word keep=00, last=1 -> no out_valid; drop_pulse high for exactly one cycle; in_ready stays 1; the following keep=01 word emits normally.
- out_ready held low for 5 cycles while holding 0x0001 -> out_data stable at 0x0001, in_ready=0; release -> transfer completes, out_count increments once.
- rst asserted while in SECOND -> next cycle out_valid=0, out_count=0, in_ready=1 after rst deasserts; CNT_W=4 with 17 emissions -> out_count=1.

Source files
------------

// File: rtl/fp16_pair_unpacker.sv
// Splits 32-bit words of two packed fp16 lanes into a stream of single fp16 values
// for the fp16-to-fp32 converter. It honours a per-lane keep mask and the packet-last marker.
module fp16_pair_unpacker #(
  parameter bit LOW_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_keep,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  state_t      state;
  logic [31:0] word_data;
  logic        word_last;
  logic        two_lanes;
  logic        is_final;
  logic        out_fire;
  logic        in_fire;

  function automatic logic [15:0] first_of(input logic [31:0] d);
    return LOW_FIRST ? d[15:0] : d[31:16];
  endfunction

  function automatic logic [15:0] second_of(input logic [31:0] d);
    return LOW_FIRST ? d[31:16] : d[15:0];
  endfunction

  assign out_valid = (state != IDLE);
  assign is_final  = (state == SECOND) || ((state == FIRST) && !two_lanes);
  assign out_fire  = out_valid && out_ready;
  // The final-lane transfer frees the word register in the same cycle, so the next word can load without a bubble.
  assign in_ready  = !rst && ((state == IDLE) || (out_fire && is_final));
  assign in_fire   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_data  <= 32'h0000_0000;
      word_last  <= 1'b0;
      two_lanes  <= 1'b0;
      out_data   <= 16'h0000;
      out_last   <= 1'b0;
      drop_pulse <= 1'b0;
      out_count  <= '0;
    end else begin
      drop_pulse <= 1'b0;
      if (out_fire)
        out_count <= out_count + CNT_W'(1);

      if (in_fire) begin
        word_data <= in_data;
        word_last <= in_last;
        case (in_keep)
          2'b11: begin
            state     <= FIRST;
            two_lanes <= 1'b1;
            out_data  <= first_of(in_data);
            out_last  <= 1'b0;
          end
          2'b01, 2'b10: begin
            state     <= FIRST;
            two_lanes <= 1'b0;
            out_data  <= in_keep[0] ? in_data[15:0] : in_data[31:16];
            out_last  <= in_last;
          end
          default: begin
            state      <= IDLE;
            two_lanes  <= 1'b0;
            out_last   <= 1'b0;
            drop_pulse <= 1'b1;
          end
        endcase
      end else if (out_fire) begin
        if ((state == FIRST) && two_lanes) begin
          state    <= SECOND;
          out_data <= second_of(word_data);
          out_last <= word_last;
        end else begin
          state    <= IDLE;
          out_last <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp16_pair_unpacker.sv
// Directed bench for fp16_pair_unpacker. Three instances share one stimulus: the default build,
// a reversed lane order, and a 4-bit counter. All three stay in handshake lockstep.
module tb_fp16_pair_unpacker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_keep;
  logic        in_last;
  logic        out_ready;

  logic        in_ready,   rev_in_ready,   c4_in_ready;
  logic        out_valid,  rev_out_valid,  c4_out_valid;
  logic [15:0] out_data,   rev_out_data,   c4_out_data;
  logic        out_last,   rev_out_last,   c4_out_last;
  logic        drop_pulse, rev_drop_pulse, c4_drop_pulse;
  logic [15:0] out_count,  rev_out_count;
  logic [3:0]  c4_out_count;

  int checks = 0;
  int errors = 0;

  fp16_pair_unpacker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .drop_pulse(drop_pulse), .out_count(out_count)
  );

  fp16_pair_unpacker #(.LOW_FIRST(1'b0)) dut_rev (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rev_in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last), .out_valid(rev_out_valid), .out_ready(out_ready),
    .out_data(rev_out_data), .out_last(rev_out_last), .drop_pulse(rev_drop_pulse),
    .out_count(rev_out_count)
  );

  fp16_pair_unpacker #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c4_in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last), .out_valid(c4_out_valid), .out_ready(out_ready),
    .out_data(c4_out_data), .out_last(c4_out_last), .drop_pulse(c4_drop_pulse),
    .out_count(c4_out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [1:0] k,
                               input logic l);
    in_valid = v;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    tick;
    tick;

    checkOutput("rst in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst out_data", {16'd0, out_data}, 32'h0);
    checkOutput("rst out_count", {16'd0, out_count}, 32'd0);
    checkOutput("rst drop_pulse", {31'd0, drop_pulse}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] single word, both lanes kept");
    applyStimulus(1'b1, 32'hC000_3C00, 2'b11, 1'b0);
    tick;
    in_valid = 1'b0;
    checkOutput("w0 lane0 data", {16'd0, out_data}, 32'h3C00);
    checkOutput("w0 lane0 valid", {31'd0, out_valid}, 32'd1);
    checkOutput("w0 lane0 last", {31'd0, out_last}, 32'd0);
    checkOutput("w0 lane0 in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("w0 rev lane1 data", {16'd0, rev_out_data}, 32'hC000);
    tick;
    checkOutput("w0 lane1 data", {16'd0, out_data}, 32'hC000);
    checkOutput("w0 lane1 last", {31'd0, out_last}, 32'd0);
    checkOutput("w0 lane1 in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("w0 rev lane0 data", {16'd0, rev_out_data}, 32'h3C00);
    tick;
    checkOutput("w0 idle valid", {31'd0, out_valid}, 32'd0);
    checkOutput("w0 count", {16'd0, out_count}, 32'd2);

    $display("[TB] three back-to-back words");
    applyStimulus(1'b1, 32'h1111_2222, 2'b11, 1'b0);
    tick;
    in_data = 32'h3333_4444;
    checkOutput("b2b o1 data", {16'd0, out_data}, 32'h2222);
    checkOutput("b2b o1 in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    checkOutput("b2b o2 data", {16'd0, out_data}, 32'h1111);
    checkOutput("b2b o2 in_ready", {31'd0, in_ready}, 32'd1);
    tick;
    applyStimulus(1'b1, 32'h5555_6666, 2'b11, 1'b1);
    checkOutput("b2b o3 data", {16'd0, out_data}, 32'h4444);
    checkOutput("b2b o3 in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    checkOutput("b2b o4 data", {16'd0, out_data}, 32'h3333);
    checkOutput("b2b o4 last", {31'd0, out_last}, 32'd0);
    checkOutput("b2b o4 in_ready", {31'd0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0;
    checkOutput("b2b o5 data", {16'd0, out_data}, 32'h6666);
    checkOutput("b2b o5 last", {31'd0, out_last}, 32'd0);
    checkOutput("b2b o5 valid", {31'd0, out_valid}, 32'd1);
    tick;
    checkOutput("b2b o6 data", {16'd0, out_data}, 32'h5555);
    checkOutput("b2b o6 last", {31'd0, out_last}, 32'd1);
    checkOutput("b2b o6 valid", {31'd0, out_valid}, 32'd1);
    tick;
    checkOutput("b2b idle valid", {31'd0, out_valid}, 32'd0);
    checkOutput("b2b count", {16'd0, out_count}, 32'd8);

    $display("[TB] single kept lane and reversed order");
    applyStimulus(1'b1, 32'h7E00_FC00, 2'b10, 1'b1);
    tick;
    in_valid = 1'b0;
    checkOutput("k10 data", {16'd0, out_data}, 32'h7E00);
    checkOutput("k10 last", {31'd0, out_last}, 32'd1);
    checkOutput("k10 in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("k10 rev data", {16'd0, rev_out_data}, 32'h7E00);
    tick;
    checkOutput("k10 idle valid", {31'd0, out_valid}, 32'd0);
    checkOutput("k10 count", {16'd0, out_count}, 32'd9);
    applyStimulus(1'b1, 32'h7E00_FC00, 2'b11, 1'b1);
    tick;
    in_valid = 1'b0;
    checkOutput("rev first data", {16'd0, rev_out_data}, 32'h7E00);
    checkOutput("rev first last", {31'd0, rev_out_last}, 32'd0);
    checkOutput("fwd first data", {16'd0, out_data}, 32'hFC00);
    tick;
    checkOutput("rev second data", {16'd0, rev_out_data}, 32'hFC00);
    checkOutput("rev second last", {31'd0, rev_out_last}, 32'd1);
    checkOutput("fwd second data", {16'd0, out_data}, 32'h7E00);
    checkOutput("fwd second last", {31'd0, out_last}, 32'd1);
    tick;
    checkOutput("rev count", {16'd0, rev_out_count}, 32'd11);

    $display("[TB] dropped empty word");
    applyStimulus(1'b1, 32'hABCD_1234, 2'b00, 1'b1);
    #1;
    checkOutput("drop in_ready before", {31'd0, in_ready}, 32'd1);
    tick;
    applyStimulus(1'b1, 32'h0000_5A5A, 2'b01, 1'b0);
    checkOutput("drop pulse", {31'd0, drop_pulse}, 32'd1);
    checkOutput("drop out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("drop in_ready after", {31'd0, in_ready}, 32'd1);
    checkOutput("drop rev pulse", {31'd0, rev_drop_pulse}, 32'd1);
    tick;
    in_valid = 1'b0;
    checkOutput("drop pulse cleared", {31'd0, drop_pulse}, 32'd0);
    checkOutput("k01 data", {16'd0, out_data}, 32'h5A5A);
    checkOutput("k01 valid", {31'd0, out_valid}, 32'd1);
    checkOutput("k01 last", {31'd0, out_last}, 32'd0);
    tick;
    checkOutput("k01 count", {16'd0, out_count}, 32'd12);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h0002_0001, 2'b01, 1'b1);
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp data", {16'd0, out_data}, 32'h0001);
      checkOutput("bp valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp last", {31'd0, out_last}, 32'd1);
      checkOutput("bp in_ready", {31'd0, in_ready}, 32'd0);
      tick;
    end
    checkOutput("bp count held", {16'd0, out_count}, 32'd12);
    out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", {31'd0, in_ready}, 32'd1);
    tick;
    checkOutput("bp idle valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp count", {16'd0, out_count}, 32'd13);

    $display("[TB] reset while in second lane");
    applyStimulus(1'b1, 32'h0BAD_0ACE, 2'b11, 1'b1);
    tick;
    in_valid = 1'b0;
    checkOutput("mid first data", {16'd0, out_data}, 32'h0ACE);
    tick;
    checkOutput("mid second data", {16'd0, out_data}, 32'h0BAD);
    rst = 1'b1;
    #1;
    checkOutput("mid rst in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    checkOutput("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid rst count", {16'd0, out_count}, 32'd0);
    checkOutput("mid rst out_last", {31'd0, out_last}, 32'd0);
    checkOutput("mid rst out_data", {16'd0, out_data}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("mid post-rst in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] counter wrap with 17 emissions");
    for (int w = 0; w < 9; w++) begin
      applyStimulus(1'b1, 32'h1000_0000 + 32'(w), (w == 8) ? 2'b01 : 2'b11, 1'b0);
      #1;
      checkOutput("wrap in_ready", {31'd0, in_ready}, 32'd1);
      tick;
      if (w != 8) tick;
    end
    in_valid = 1'b0;
    tick;
    checkOutput("wrap c4 count", {28'd0, c4_out_count}, 32'd1);
    checkOutput("wrap main count", {16'd0, out_count}, 32'd17);
    checkOutput("wrap idle valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
